// File: rtl/ysyx_24100006_pkg.sv
// Shared encodings for the memory-access stage: access class, funct3 size
// codes and the MEMU state enum.
package ysyx_24100006_pkg;

   localparam logic [1:0] RW_NONE  = 2'b00;
   localparam logic [1:0] RW_LOAD  = 2'b01;
   localparam logic [1:0] RW_STORE = 2'b10;
   localparam logic [1:0] RW_RSVD  = 2'b11;

   localparam logic [2:0] MASK_B  = 3'b000;
   localparam logic [2:0] MASK_H  = 3'b001;
   localparam logic [2:0] MASK_W  = 3'b010;
   localparam logic [2:0] MASK_BU = 3'b100;
   localparam logic [2:0] MASK_HU = 3'b101;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_A,
      ST_RD_D,
      ST_WR,
      ST_WR_B,
      ST_DONE
   } memu_state_e;

   // Halfwords must sit on even addresses, words on multiples of four.
   function automatic logic is_misaligned(input logic [2:0] mask, input logic [1:0] addr_lo);
      logic mis;
      mis = 1'b0;
      case (mask)
         MASK_H, MASK_HU: mis = addr_lo[0];
         MASK_W:          mis = (addr_lo != 2'b00);
         default:         mis = 1'b0;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/ysyx_24100006_memu_if.sv
// AXI4-Lite-style data bus between the MEM stage (master) and memory (slave).
interface ysyx_24100006_memu_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0]   araddr;
   logic                arvalid;
   logic                arready;
   logic [DATA_W-1:0]   rdata;
   logic [1:0]          rresp;
   logic                rvalid;
   logic                rready;
   logic [ADDR_W-1:0]   awaddr;
   logic                awvalid;
   logic                awready;
   logic [DATA_W-1:0]   wdata;
   logic [DATA_W/8-1:0] wstrb;
   logic                wvalid;
   logic                wready;
   logic [1:0]          bresp;
   logic                bvalid;
   logic                bready;

   modport master (
      output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
      input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
   );

   modport slave (
      input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
      output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
   );
endinterface

// File: rtl/ysyx_24100006_lsu_align.sv
// Combinational lane handling: store data replication and byte strobes,
// load lane extraction with sign/zero extension.
module ysyx_24100006_lsu_align
   import ysyx_24100006_pkg::*;
(
   input  logic [2:0]  mask,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] store_data,
   input  logic [31:0] rdata,
   output logic [31:0] wdata,
   output logic [3:0]  wstrb,
   output logic [31:0] load_data
);

   logic [31:0] shifted;
   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   // Store side: every lane carries the datum so the strobe alone selects the target bytes.
   always_comb begin
      wdata = store_data;
      wstrb = 4'b1111;
      case (mask)
         MASK_B, MASK_BU: begin
            wdata = {4{store_data[7:0]}};
            wstrb = 4'b0001 << addr_lo;
         end
         MASK_H, MASK_HU: begin
            wdata = {2{store_data[15:0]}};
            wstrb = 4'b0011 << addr_lo;
         end
         default: begin
            wdata = store_data;
            wstrb = 4'b1111;
         end
      endcase
   end

   // Load side: shift the addressed lane down to bit 0, then extend.
   always_comb begin
      shifted   = rdata >> {addr_lo, 3'b000};
      lane_b    = shifted[7:0];
      lane_h    = shifted[15:0];
      load_data = rdata;
      case (mask)
         MASK_B:  load_data = {{24{lane_b[7]}}, lane_b};
         MASK_BU: load_data = {24'h0, lane_b};
         MASK_H:  load_data = {{16{lane_h[15]}}, lane_h};
         MASK_HU: load_data = {16'h0, lane_h};
         default: load_data = rdata;
      endcase
   end

endmodule

// File: rtl/ysyx_24100006_memu.sv
// Memory-access stage: one bus transaction at a time between EXE_MEM and MEM_WB.
//
// state | meaning
// IDLE  | empty, ready for an instruction
// RD_A  | read address offered (arvalid)
// RD_D  | waiting for read data (rready)
// WR    | address and data offered, each tracked by a sticky accept flag
// WR_B  | waiting for write response (bready)
// DONE  | result held for MEM_WB (mem_in_valid)
module ysyx_24100006_memu
   import ysyx_24100006_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_out_valid,
   output logic        mem_out_ready,
   output logic        mem_in_valid,
   input  logic        mem_in_ready,
   input  logic [31:0] alu_result_M,
   input  logic [31:0] wdata_gpr_M,
   input  logic [31:0] wdata_csr_M,
   input  logic [1:0]  sram_read_write_M,
   input  logic [2:0]  Mem_Mask_M,
   input  logic        Gpr_Write_M,
   input  logic        Csr_Write_M,
   input  logic        irq_M,
   input  logic [3:0]  Gpr_Write_Addr_M,
   input  logic [11:0] Csr_Write_Addr_M,
   input  logic [3:0]  irq_no_M,
   output logic        Gpr_Write_W,
   output logic        Csr_Write_W,
   output logic        irq_W,
   output logic [3:0]  Gpr_Write_Addr_W,
   output logic [11:0] Csr_Write_Addr_W,
   output logic [3:0]  irq_no_W,
   output logic [31:0] wdata_gpr_W,
   output logic [31:0] wdata_csr_W,
   output logic        access_fault_W,
   ysyx_24100006_memu_if.master bus,
   output logic        mem_is_load,
   output logic [31:0] mem_fw_data
);

   localparam int STRB_W = DATA_W / 8;

   memu_state_e state_q, state_d, dispatch;
   logic [31:0] addr_q, store_q;
   logic [2:0]  mask_q;
   logic        aw_done_q, w_done_q;
   logic        accept, mis_m, aw_ok, w_ok;
   logic [31:0] aligned_addr, st_wdata, ld_data;
   logic [3:0]  st_strb;

   ysyx_24100006_lsu_align u_align (
      .mask       (mask_q),
      .addr_lo    (addr_q[1:0]),
      .store_data (store_q),
      .rdata      (bus.rdata[31:0]),
      .wdata      (st_wdata),
      .wstrb      (st_strb),
      .load_data  (ld_data)
   );

   assign aligned_addr = {addr_q[31:2], 2'b00};

   assign bus.arvalid = (state_q == ST_RD_A);
   assign bus.araddr  = ADDR_W'(aligned_addr);
   assign bus.rready  = (state_q == ST_RD_D);
   assign bus.awvalid = (state_q == ST_WR) && !aw_done_q;
   assign bus.awaddr  = ADDR_W'(aligned_addr);
   assign bus.wvalid  = (state_q == ST_WR) && !w_done_q;
   assign bus.wdata   = DATA_W'(st_wdata);
   assign bus.wstrb   = STRB_W'(st_strb);
   assign bus.bready  = (state_q == ST_WR_B);

   assign mem_in_valid = (state_q == ST_DONE);
   assign mem_is_load  = (state_q == ST_RD_A) || (state_q == ST_RD_D);
   assign mem_fw_data  = wdata_gpr_W;

   // Next state; DONE can hand over to a new instruction in the same cycle.
   always_comb begin
      mem_out_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && mem_in_ready);
      accept        = mem_out_valid && mem_out_ready;
      mis_m         = ((sram_read_write_M == RW_LOAD) || (sram_read_write_M == RW_STORE)) &&
                      is_misaligned(Mem_Mask_M, alu_result_M[1:0]);
      if ((sram_read_write_M == RW_LOAD) && !mis_m)
         dispatch = ST_RD_A;
      else if ((sram_read_write_M == RW_STORE) && !mis_m)
         dispatch = ST_WR;
      else
         dispatch = ST_DONE;
      aw_ok   = aw_done_q || bus.awready;
      w_ok    = w_done_q || bus.wready;
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (accept) state_d = dispatch;
         ST_RD_A: if (bus.arready) state_d = ST_RD_D;
         ST_RD_D: if (bus.rvalid) state_d = ST_DONE;
         ST_WR:   if (aw_ok && w_ok) state_d = ST_WR_B;
         ST_WR_B: if (bus.bvalid) state_d = ST_DONE;
         ST_DONE: if (mem_in_ready) state_d = accept ? dispatch : ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Instruction latch, result register and write-channel accept flags.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         addr_q           <= '0;
         store_q          <= '0;
         mask_q           <= '0;
         aw_done_q        <= 1'b0;
         w_done_q         <= 1'b0;
         Gpr_Write_W      <= 1'b0;
         Csr_Write_W      <= 1'b0;
         irq_W            <= 1'b0;
         Gpr_Write_Addr_W <= '0;
         Csr_Write_Addr_W <= '0;
         irq_no_W         <= '0;
         wdata_gpr_W      <= '0;
         wdata_csr_W      <= '0;
         access_fault_W   <= 1'b0;
      end else if (accept) begin
         addr_q           <= alu_result_M;
         store_q          <= wdata_gpr_M;
         mask_q           <= Mem_Mask_M;
         aw_done_q        <= 1'b0;
         w_done_q         <= 1'b0;
         Gpr_Write_W      <= Gpr_Write_M && !mis_m;
         Csr_Write_W      <= Csr_Write_M;
         irq_W            <= irq_M;
         Gpr_Write_Addr_W <= Gpr_Write_Addr_M;
         Csr_Write_Addr_W <= Csr_Write_Addr_M;
         irq_no_W         <= irq_no_M;
         wdata_gpr_W      <= wdata_gpr_M;
         wdata_csr_W      <= wdata_csr_M;
         access_fault_W   <= mis_m;
      end else begin
         case (state_q)
            ST_RD_D: begin
               if (bus.rvalid) begin
                  wdata_gpr_W    <= ld_data;
                  access_fault_W <= (bus.rresp != 2'b00);
               end
            end
            ST_WR: begin
               if (bus.awready) aw_done_q <= 1'b1;
               if (bus.wready)  w_done_q  <= 1'b1;
            end
            ST_WR_B: begin
               if (bus.bvalid) access_fault_W <= (bus.bresp != 2'b00);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_24100006_memu.sv
// Scoreboard bench for the MEM stage with a simple programmable bus slave.
module tb_ysyx_24100006_memu;
   import ysyx_24100006_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   logic        mem_out_valid, mem_out_ready, mem_in_valid, mem_in_ready;
   logic [31:0] alu_result_M, wdata_gpr_M, wdata_csr_M;
   logic [1:0]  sram_read_write_M;
   logic [2:0]  Mem_Mask_M;
   logic        Gpr_Write_M, Csr_Write_M, irq_M;
   logic [3:0]  Gpr_Write_Addr_M, irq_no_M;
   logic [11:0] Csr_Write_Addr_M;
   logic        Gpr_Write_W, Csr_Write_W, irq_W;
   logic [3:0]  Gpr_Write_Addr_W, irq_no_W;
   logic [11:0] Csr_Write_Addr_W;
   logic [31:0] wdata_gpr_W, wdata_csr_W, mem_fw_data;
   logic        access_fault_W, mem_is_load;

   ysyx_24100006_memu_if bus ();

   // Slave: zero-wait by default; r_en / w_en stall the data phases.
   logic        r_en = 1'b1, w_en = 1'b1;
   logic [31:0] rdata_v = '0;
   logic [1:0]  rresp_v = '0, bresp_v = '0;
   assign bus.arready = 1'b1;
   assign bus.rvalid  = bus.rready && r_en;
   assign bus.rdata   = rdata_v;
   assign bus.rresp   = rresp_v;
   assign bus.awready = 1'b1;
   assign bus.wready  = w_en;
   assign bus.bvalid  = bus.bready;
   assign bus.bresp   = bresp_v;

   ysyx_24100006_memu dut (
      .clk(clk), .reset(reset),
      .mem_out_valid(mem_out_valid), .mem_out_ready(mem_out_ready),
      .mem_in_valid(mem_in_valid), .mem_in_ready(mem_in_ready),
      .alu_result_M(alu_result_M), .wdata_gpr_M(wdata_gpr_M), .wdata_csr_M(wdata_csr_M),
      .sram_read_write_M(sram_read_write_M), .Mem_Mask_M(Mem_Mask_M),
      .Gpr_Write_M(Gpr_Write_M), .Csr_Write_M(Csr_Write_M), .irq_M(irq_M),
      .Gpr_Write_Addr_M(Gpr_Write_Addr_M), .Csr_Write_Addr_M(Csr_Write_Addr_M), .irq_no_M(irq_no_M),
      .Gpr_Write_W(Gpr_Write_W), .Csr_Write_W(Csr_Write_W), .irq_W(irq_W),
      .Gpr_Write_Addr_W(Gpr_Write_Addr_W), .Csr_Write_Addr_W(Csr_Write_Addr_W), .irq_no_W(irq_no_W),
      .wdata_gpr_W(wdata_gpr_W), .wdata_csr_W(wdata_csr_W), .access_fault_W(access_fault_W),
      .bus(bus), .mem_is_load(mem_is_load), .mem_fw_data(mem_fw_data)
   );

   typedef struct {
      logic [31:0] gdata;
      logic [31:0] cdata;
      logic        fault;
      logic [22:0] side;
      int          due;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] exp_ar[$];
   logic [31:0] exp_aw[$];
   logic [35:0] exp_w[$];
   exp_t        mon_e;
   logic [35:0] mon_w;
   int          cyc = 0;
   int          checks = 0;
   int          failures = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%h want=%h t=%0t", tag, got, want, $time);
      end
   endtask

   function automatic logic m_mis(input logic [2:0] mk, input logic [31:0] a);
      if (mk == 3'b001 || mk == 3'b101) return a[0] == 1'b1;
      if (mk == 3'b010) return a[1:0] != 2'b00;
      return 1'b0;
   endfunction

   function automatic logic [31:0] m_load(input logic [2:0] mk, input logic [1:0] a, input logic [31:0] d);
      logic [7:0]  b;
      logic [15:0] h;
      case (a)
         2'd0: b = d[7:0];
         2'd1: b = d[15:8];
         2'd2: b = d[23:16];
         default: b = d[31:24];
      endcase
      h = (a >= 2'd2) ? d[31:16] : d[15:0];
      case (mk)
         3'b000: return {{24{b[7]}}, b};
         3'b100: return {24'h0, b};
         3'b001: return {{16{h[15]}}, h};
         3'b101: return {16'h0, h};
         default: return d;
      endcase
   endfunction

   function automatic logic [35:0] m_store(input logic [2:0] mk, input logic [1:0] a, input logic [31:0] g);
      logic [3:0] s;
      if (mk == 3'b000) begin
         s = (a == 2'd0) ? 4'b0001 : (a == 2'd1) ? 4'b0010 : (a == 2'd2) ? 4'b0100 : 4'b1000;
         return {s, g[7:0], g[7:0], g[7:0], g[7:0]};
      end
      if (mk == 3'b001) begin
         s = a[1] ? 4'b1100 : 4'b0011;
         return {s, g[15:0], g[15:0]};
      end
      return {4'b1111, g};
   endfunction

   task automatic sync();
      @(posedge clk);
      #1;
   endtask

   // Drive one instruction (call just after a rising edge), wait for acceptance, record expectations.
   task automatic issue(input logic [1:0] rw, input logic [2:0] mk, input logic [31:0] addr,
                        input logic [31:0] gdata, input logic gw, input int lat);
      exp_t e;
      logic mis;
      int   n;
      mis = (rw == 2'b01 || rw == 2'b10) && m_mis(mk, addr);
      sram_read_write_M = rw;
      Mem_Mask_M        = mk;
      alu_result_M      = addr;
      wdata_gpr_M       = gdata;
      Gpr_Write_M       = gw;
      wdata_csr_M       = $urandom;
      Csr_Write_M       = 1'($urandom_range(1));
      irq_M             = 1'($urandom_range(1));
      Gpr_Write_Addr_M  = 4'($urandom_range(15));
      irq_no_M          = 4'($urandom_range(15));
      Csr_Write_Addr_M  = 12'($urandom_range(4095));
      e.gdata = (rw == 2'b01 && !mis) ? m_load(mk, addr[1:0], rdata_v) : gdata;
      e.cdata = wdata_csr_M;
      e.fault = mis || (rw == 2'b01 && rresp_v != 2'b00) || (rw == 2'b10 && bresp_v != 2'b00);
      e.side  = {gw && !mis, Csr_Write_M, irq_M, Gpr_Write_Addr_M, irq_no_M, Csr_Write_Addr_M};
      if (rw == 2'b01 && !mis) exp_ar.push_back({addr[31:2], 2'b00});
      if (rw == 2'b10 && !mis) begin
         exp_aw.push_back({addr[31:2], 2'b00});
         exp_w.push_back(m_store(mk, addr[1:0], gdata));
      end
      mem_out_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!mem_out_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("accept", 32'(mem_out_ready), 1);
      e.due = (lat < 0) ? -1 : cyc + 1 + lat;
      sb.push_back(e);
      @(posedge clk);
      #1 mem_out_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("drain", 32'(sb.size()), 0);
      sync();
   endtask

   // Output and bus monitors.
   always @(negedge clk) begin
      if (reset) begin
         if (mem_in_valid && mem_in_ready) begin
            chk("sb_nonempty", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
               mon_e = sb.pop_front();
               chk("wdata_gpr", wdata_gpr_W, mon_e.gdata);
               chk("fw_data", mem_fw_data, mon_e.gdata);
               chk("wdata_csr", wdata_csr_W, mon_e.cdata);
               chk("fault", 32'(access_fault_W), 32'(mon_e.fault));
               chk("sideband", 32'({Gpr_Write_W, Csr_Write_W, irq_W, Gpr_Write_Addr_W, irq_no_W, Csr_Write_Addr_W}),
                   32'(mon_e.side));
               if (mon_e.due >= 0) chk("latency", 32'(cyc), 32'(mon_e.due));
            end
         end
         if (bus.arvalid && bus.arready) begin
            chk("ar_expected", 32'(exp_ar.size() != 0), 1);
            if (exp_ar.size() != 0) chk("araddr", bus.araddr, exp_ar.pop_front());
         end
         if (bus.awvalid && bus.awready) begin
            chk("aw_expected", 32'(exp_aw.size() != 0), 1);
            if (exp_aw.size() != 0) chk("awaddr", bus.awaddr, exp_aw.pop_front());
         end
         if (bus.wvalid && bus.wready) begin
            chk("w_expected", 32'(exp_w.size() != 0), 1);
            if (exp_w.size() != 0) begin
               mon_w = exp_w.pop_front();
               chk("wdata", bus.wdata, mon_w[31:0]);
               chk("wstrb", 32'(bus.wstrb), 32'(mon_w[35:32]));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      mem_out_valid = 1'b0; mem_in_ready = 1'b1;
      alu_result_M = '0; wdata_gpr_M = '0; wdata_csr_M = '0;
      sram_read_write_M = RW_NONE; Mem_Mask_M = MASK_W;
      Gpr_Write_M = 1'b0; Csr_Write_M = 1'b0; irq_M = 1'b0;
      Gpr_Write_Addr_M = '0; irq_no_M = '0; Csr_Write_Addr_M = '0;

      repeat (3) @(negedge clk);
      chk("rst_valids", 32'({bus.arvalid, bus.awvalid, bus.wvalid, bus.rready, bus.bready, mem_in_valid}), 0);
      chk("rst_wdata_gpr", wdata_gpr_W, 0);
      chk("rst_fault_side", 32'({access_fault_W, Gpr_Write_W, Csr_Write_W, irq_W, Gpr_Write_Addr_W}), 0);
      sync();
      reset = 1'b1;
      sync();

      // Non-memory pass-through.
      issue(RW_NONE, MASK_W, 32'h0000_1234, 32'h0000_00AB, 1'b1, 0);
      @(negedge clk);
      chk("nm_no_bus", 32'({bus.arvalid, bus.awvalid, bus.wvalid}), 0);
      chk("nm_valid", 32'(mem_in_valid), 1);
      chk("nm_data", wdata_gpr_W, 32'h0000_00AB);
      drain();

      // lb with cycle-by-cycle load-use tracking.
      rdata_v = 32'h80FF_0011;
      issue(RW_LOAD, MASK_B, 32'h8000_0003, 32'h0, 1'b1, 2);
      @(negedge clk);
      chk("lb_ra_is_load", 32'(mem_is_load), 1);
      chk("lb_araddr", bus.araddr, 32'h8000_0000);
      @(negedge clk);
      chk("lb_rd_is_load", 32'({mem_is_load, bus.rready}), 32'b11);
      @(negedge clk);
      chk("lb_done_is_load", 32'(mem_is_load), 0);
      chk("lb_result", wdata_gpr_W, 32'hFFFF_FF80);
      drain();

      issue(RW_LOAD, MASK_BU, 32'h8000_0003, 32'h0, 1'b1, 2);
      drain();
      chk("lbu_result", wdata_gpr_W, 32'h0000_0080);
      issue(RW_LOAD, MASK_H, 32'h8000_0002, 32'h0, 1'b1, 2);
      drain();
      issue(RW_LOAD, MASK_HU, 32'h8000_0002, 32'h0, 1'b1, 2);
      drain();
      rdata_v = 32'h1357_9BDF;
      issue(RW_LOAD, MASK_W, 32'h8000_0010, 32'h0, 1'b1, 2);
      issue(RW_LOAD, MASK_B, 32'h8000_0011, 32'h0, 1'b1, 2);
      drain();

      // Stores, zero-wait.
      issue(RW_STORE, MASK_B, 32'h8000_0001, 32'h0000_00A5, 1'b0, 2);
      drain();
      issue(RW_STORE, MASK_W, 32'h8000_0020, 32'hDEAD_BEEF, 1'b0, 2);
      drain();

      // sh with W accepted one cycle after AW.
      w_en = 1'b0;
      issue(RW_STORE, MASK_H, 32'h8000_0002, 32'h1234_BEEF, 1'b0, -1);
      @(negedge clk);
      chk("sh_both_valid", 32'({bus.awvalid, bus.wvalid, bus.bready}), 32'b110);
      chk("sh_wstrb", 32'(bus.wstrb), 32'b1100);
      chk("sh_wdata", bus.wdata, 32'hBEEF_BEEF);
      sync();
      w_en = 1'b1;
      @(negedge clk);
      chk("sh_w_only", 32'({bus.awvalid, bus.wvalid, bus.bready}), 32'b010);
      @(negedge clk);
      chk("sh_bready", 32'({bus.awvalid, bus.wvalid, bus.bready}), 32'b001);
      drain();

      // Misaligned accesses: no bus traffic, fault flagged, GPR write suppressed.
      issue(RW_LOAD, MASK_W, 32'h8000_0001, 32'h0000_5555, 1'b1, 0);
      @(negedge clk);
      chk("mis_lw", 32'({bus.arvalid, access_fault_W, Gpr_Write_W}), 32'b010);
      drain();
      issue(RW_STORE, MASK_H, 32'h8000_0003, 32'h0000_7777, 1'b1, 0);
      drain();

      // Error responses.
      rresp_v = 2'b10;
      issue(RW_LOAD, MASK_W, 32'h8000_0040, 32'h0, 1'b1, 2);
      drain();
      rresp_v = 2'b00;
      bresp_v = 2'b11;
      issue(RW_STORE, MASK_W, 32'h8000_0044, 32'h0BAD_F00D, 1'b0, 2);
      drain();
      bresp_v = 2'b00;

      // Back-pressure in DONE, then release with the next instruction waiting.
      mem_in_ready = 1'b0;
      issue(RW_NONE, MASK_W, 32'h0000_0010, 32'h0000_1111, 1'b1, -1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("hold_ready", 32'({mem_out_ready, mem_in_valid}), 32'b01);
         chk("hold_data", wdata_gpr_W, 32'h0000_1111);
      end
      sync();
      mem_in_ready = 1'b1;
      issue(RW_NONE, MASK_W, 32'h0000_0020, 32'h0000_2222, 1'b1, 0);
      @(negedge clk);
      chk("b2b_data", wdata_gpr_W, 32'h0000_2222);
      drain();

      // Reset while waiting for read data.
      r_en = 1'b0;
      issue(RW_LOAD, MASK_W, 32'h8000_0008, 32'h0, 1'b1, -1);
      @(negedge clk);
      sync();
      chk("rd_wait", 32'({mem_is_load, bus.rready}), 32'b11);
      reset = 1'b0;
      #1;
      chk("arst_ctl", 32'({bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready, mem_in_valid, mem_is_load}), 0);
      chk("arst_data", wdata_gpr_W, 0);
      chk("arst_side", 32'({access_fault_W, Gpr_Write_W, Csr_Write_W, irq_W, Gpr_Write_Addr_W, Csr_Write_Addr_W}), 0);
      sb.delete();
      r_en = 1'b1;
      sync();
      reset = 1'b1;
      @(negedge clk);
      chk("post_rst_idle", 32'({mem_out_ready, bus.rready, mem_in_valid}), 32'b100);
      sync();
      issue(RW_RSVD, MASK_W, 32'h8000_0003, 32'h0000_3333, 1'b1, 0);
      drain();

      chk("end_sb", 32'(sb.size()), 0);
      chk("end_bus_q", 32'(exp_ar.size() + exp_aw.size() + exp_w.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ysyx_24100006_memu.md
# ysyx_24100006_memu

Memory-access stage of the five-stage core: sits directly downstream of the EXE_MEM register and feeds MEM_WB. It takes the execute stage's address (`alu_result`), store data, access size and load/store class, and runs one transaction at a time on an AXI4-Lite-style data bus. Load data is lane-aligned and sign/zero-extended; the result is held in an output register with valid/ready handshakes on both sides. It also drives the MEM-stage forwarding/load-use outputs.

## Interface
Parameters:
- `ADDR_W`, 32: data bus address width.
- `DATA_W`, 32: data bus width; only 32 is supported.

Ports:
- `clk`  in  1  core clock.
- `reset`  in  1  asynchronous, active-low reset.
- `mem_out_valid` / `mem_out_ready`  in / out  1  upstream handshake with EXE_MEM.
- `mem_in_valid` / `mem_in_ready`  out / in  1  downstream handshake with MEM_WB.
- `alu_result_M`  in  32  access address; passed through as a result for non-memory instructions.
- `wdata_gpr_M`  in  32  GPR write data; for stores this is the store data (rs2).
- `wdata_csr_M`  in  32  CSR write data; passed through.
- `sram_read_write_M`  in  2  `00` none, `01` load, `10` store, `11` reserved (treated as none).
- `Mem_Mask_M`  in  3  funct3 encoding: `000` b, `001` h, `010` w, `100` bu, `101` hu.
- `Gpr_Write_M`, `Csr_Write_M`, `irq_M`  in  1  side-band; registered and passed through.
- `Gpr_Write_Addr_M`, `Csr_Write_Addr_M`, `irq_no_M`  in  4/12/4  side-band; registered and passed through.
- `*_W` outputs  out  same widths  registered copies of the side-band, plus `wdata_gpr_W` and `wdata_csr_W`.
- `access_fault_W`  out  1  set when the held result came from a misaligned access or a non-OKAY bus response.
- `araddr`, `arvalid`, `arready`, `rdata`, `rresp`, `rvalid`, `rready`  read channel.
- `awaddr`, `awvalid`, `awready`, `wdata`, `wstrb`, `wvalid`, `wready`, `bresp`, `bvalid`, `bready`  write channel.
- `mem_is_load`  out  1  a load occupies the stage and its data is not yet in the output register.
- `mem_fw_data`  out  32  equals `wdata_gpr_W`; meaningful when `mem_in_valid` is high.

## Operation
- FSM states: IDLE, RD_A, RD_D, WR, WR_B, DONE.
- `mem_out_ready = (state==IDLE) || (state==DONE && mem_in_ready)`. Acceptance happens on `mem_out_valid && mem_out_ready`.
- On acceptance:
  - All inputs are latched.
  - Load → RD_A; store → WR.
  - None or reserved → DONE, with `wdata_gpr_W = wdata_gpr_M`.
  - Misaligned access (h with `addr[0]` set, w with `addr[1:0]` non-zero) → DONE with `access_fault_W=1`. No bus activity; `Gpr_Write_W` is forced to 0.
- RD_A: `arvalid=1` and `araddr = {addr[31:2],2'b00}`. Goes to RD_D on `arready`.
- RD_D: `rready=1`. On `rvalid`:
  - The lane is selected by `addr[1:0]` and extended per `Mem_Mask`; the result goes to `wdata_gpr_W`.
  - `access_fault_W = (rresp!=0)`.
  - Next state is DONE.
- WR: `awvalid` and `wvalid` are both asserted.
  - `wdata` is the store data replicated into every lane: b into all bytes, h into both halves.
  - `wstrb` is `0001<<a` for byte, `0011<<a` for halfword, `1111` for word.
  - AW and W are accepted independently, tracked by two sticky flags. The state moves to WR_B once both have been accepted, which may be in the same cycle.
- WR_B: `bready=1`. On `bvalid`: `access_fault_W = (bresp!=0)`, then DONE. Stores pass `Gpr_Write` through unchanged (it is 0 from decode).
- DONE: `mem_in_valid=1`.
  - On `mem_in_ready` with no new acceptance → IDLE.
  - On `mem_in_ready` with a simultaneous acceptance → branch directly per the new instruction, with no bubble.
- `mem_is_load = 1` in RD_A, and in RD_D up to and including the `rvalid` cycle.

## Timing
- Reset values: state IDLE; every bus valid/ready output 0; `mem_in_valid` 0; all `*_W` registers and `access_fault_W` 0.
- Non-memory instruction: accepted at edge N, `mem_in_valid` at N+1.
- Load with zero-wait bus: accept at N; `arvalid` in cycle N+1, `rvalid` in N+2, `mem_in_valid` at N+3.
- Store with zero-wait bus: `mem_in_valid` at N+3.
- Once asserted, bus valids and their payloads stay stable until the handshake completes.
- While in DONE, outputs hold until `mem_in_ready`.
- Reset mid-transaction returns to IDLE immediately. The bus slave must tolerate the abandoned request.

## Structure
- Shared package `ysyx_24100006_pkg` holds the `sram_read_write` encodings, the `Mem_Mask` funct3 constants and the FSM state enum.
- One natural sub-module, `ysyx_24100006_lsu_align`. It is combinational and does store lane replication and strobe generation plus load extraction and extension.

## Test plan
- Non-memory: `alu_result=0x1234`, `wdata_gpr=0xAB` → `mem_in_valid` one cycle later with `wdata_gpr_W=0xAB` and no bus valids.
- `lb` at `0x8000_0003`, `rdata=0x80FF_0011` → `araddr=0x8000_0000`, `wdata_gpr_W=0xFFFF_FF80`. Repeated as `lbu` → `0x0000_0080`.
- `sh` of `0x1234_BEEF` at `0x8000_0002` → `wstrb=1100`, `wdata=0xBEEF_BEEF`. With `awready` one cycle before `wready`, `bready` asserts only after both.
- `lw` at `0x8000_0001` → no `arvalid`, `access_fault_W=1`, `Gpr_Write_W=0`.
- Back-to-back: hold `mem_in_ready=0` for 3 cycles in DONE → `mem_out_ready=0` and the result is held. Releasing it with an upstream valid present accepts the next instruction in the same cycle.
- `reset` asserted during RD_D → all outputs go to 0 asynchronously and the FSM is in IDLE after release.
